// File: rtl/seg_display_sched.sv
// ---------------------------------------------------------------------------
// seg_display_sched
//
// Picks which processor value is shown on the 8-digit seven-segment display.
// Each requester posts a value with a valid/ack handshake. The block keeps one
// shadow register per source and remembers which sources have ever been loaded.
// In auto mode it steps through the loaded sources on a dwell timer. In manual
// mode it shows whichever source manual_sel_i points at. freeze_i holds the
// picture and stops the timer, but captures keep landing in the shadows.
//
// Ports
//   clk_i          system clock, rising edge
//   rst_ni         synchronous active-low reset
//   src_valid_i    per-source request, held high until acknowledged
//   src_data_i     source i value at [i*DATA_W +: DATA_W]
//   src_ack_o      one-cycle capture acknowledge per source
//   mode_auto_i    1 = rotate on the dwell timer, 0 = manual select
//   manual_sel_i   source shown while mode_auto_i = 0
//   freeze_i       hold the displayed value and stop the dwell timer
//   disp_data_o    value for the hex decoders (nibble k drives HEXk)
//   disp_src_o     index of the source whose value is in disp_data_o
//   disp_blank_o   bit k = 1 blanks digit k (leading-zero suppression)
//   dwell_tick_o   one-cycle pulse each time the auto rotation advances
// ---------------------------------------------------------------------------
module seg_display_sched #(
   parameter int NUM_SRC      = 4,
   parameter int DATA_W       = 32,
   parameter int DWELL_CYCLES = 50_000_000
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic [NUM_SRC-1:0]           src_valid_i,
   input  logic [NUM_SRC*DATA_W-1:0]    src_data_i,
   output logic [NUM_SRC-1:0]           src_ack_o,
   input  logic                         mode_auto_i,
   input  logic [$clog2(NUM_SRC)-1:0]   manual_sel_i,
   input  logic                         freeze_i,
   output logic [DATA_W-1:0]            disp_data_o,
   output logic [$clog2(NUM_SRC)-1:0]   disp_src_o,
   output logic [7:0]                   disp_blank_o,
   output logic                         dwell_tick_o
);

   localparam int SEL_W = $clog2(NUM_SRC);
   localparam int CNT_W = $clog2(DWELL_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(DWELL_CYCLES - 1);
   localparam logic [7:0]       BLANK_RST = 8'hFE;

   typedef enum logic [1:0] {
      IDLE,
      SHOW,
      HOLD
   } state_e;

   state_e               state_q, state_d;
   logic [NUM_SRC-1:0]   ack_q, ack_d;
   logic [NUM_SRC-1:0]   loaded_q, loaded_d;
   logic [DATA_W-1:0]    shadow_q [NUM_SRC];
   logic [DATA_W-1:0]    shadow_d [NUM_SRC];
   logic [SEL_W-1:0]     cur_q, cur_d;
   logic [CNT_W-1:0]     dwell_q, dwell_d;
   logic [DATA_W-1:0]    disp_q, disp_d;
   logic [7:0]           blank_q, blank_d;
   logic                 tick_q, tick_d;

   logic [SEL_W-1:0]     lowestIdx;
   logic [SEL_W-1:0]     nextIdx;
   logic                 foundNext;
   logic                 loadDisp;
   logic [DATA_W-1:0]    showVal;
   logic [7:0]           blankNext;
   logic                 allZero;

   // Capture path. A source is taken whenever it is valid and was not acked
   // in the previous cycle, which gives one capture every second cycle to a
   // requester that keeps valid high. Sources are independent and capture
   // carries on regardless of the display state or freeze.
   always_comb begin
      ack_d    = '0;
      loaded_d = loaded_q;
      for (int i = 0; i < NUM_SRC; i++) begin
         shadow_d[i] = shadow_q[i];
         if (src_valid_i[i] && !ack_q[i]) begin
            shadow_d[i] = src_data_i[i*DATA_W +: DATA_W];
            loaded_d[i] = 1'b1;
            ack_d[i]    = 1'b1;
         end
      end
   end

   // Lowest loaded index, used when leaving IDLE in auto mode and as the
   // wrap-around target of the rotation.
   always_comb begin
      lowestIdx = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (loaded_q[i]) begin
            lowestIdx = SEL_W'(i);
         end
      end
   end

   // Next loaded index above the current one. When nothing above is loaded
   // the rotation wraps to the lowest loaded index, which is the current one
   // itself when it is the only loaded source.
   always_comb begin
      nextIdx   = lowestIdx;
      foundNext = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (!foundNext && loaded_q[i] && (SEL_W'(i) > cur_q)) begin
            nextIdx   = SEL_W'(i);
            foundNext = 1'b1;
         end
      end
   end

   // Display sequencer. cur_q doubles as disp_src_o so the index and the
   // value it selects are always registered on the same edge. loadDisp marks
   // the cycles in which the display registers take a fresh value.
   always_comb begin
      state_d  = state_q;
      cur_d    = cur_q;
      dwell_d  = dwell_q;
      tick_d   = 1'b0;
      loadDisp = 1'b0;
      case (state_q)
         IDLE: begin
            if (|loaded_q) begin
               state_d  = SHOW;
               cur_d    = mode_auto_i ? lowestIdx : manual_sel_i;
               dwell_d  = '0;
               loadDisp = 1'b1;
            end
         end
         SHOW: begin
            if (freeze_i) begin
               state_d = HOLD;
            end else begin
               loadDisp = 1'b1;
               if (!mode_auto_i) begin
                  // Holding the counter at zero here is what makes a later
                  // switch to auto start a full dwell from the current source.
                  cur_d   = manual_sel_i;
                  dwell_d = '0;
               end else if (dwell_q == CNT_MAX) begin
                  dwell_d = '0;
                  cur_d   = nextIdx;
                  tick_d  = 1'b1;
               end else begin
                  dwell_d = dwell_q + CNT_W'(1);
               end
            end
         end
         HOLD: begin
            if (!freeze_i) begin
               state_d  = SHOW;
               loadDisp = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Value for the source about to be shown. A source that has never been
   // loaded shows zero.
   always_comb begin
      showVal = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if ((cur_d == SEL_W'(i)) && loaded_q[i]) begin
            showVal = shadow_q[i];
         end
      end
   end

   // Leading-zero suppression. Digit k blanks only when it and every digit
   // above it are zero; digit 0 is always lit so a zero value still shows "0".
   always_comb begin
      allZero   = 1'b1;
      blankNext = '0;
      for (int k = 7; k >= 1; k--) begin
         allZero      = allZero & (showVal[4*k +: 4] == 4'h0);
         blankNext[k] = allZero;
      end
   end

   assign disp_d  = loadDisp ? showVal   : disp_q;
   assign blank_d = loadDisp ? blankNext : blank_q;

   // State and data registers. Reset drops any capture in flight, so a
   // requester still holding valid is taken on the first cycle after release.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q  <= IDLE;
         ack_q    <= '0;
         loaded_q <= '0;
         cur_q    <= '0;
         dwell_q  <= '0;
         disp_q   <= '0;
         blank_q  <= BLANK_RST;
         tick_q   <= 1'b0;
         for (int i = 0; i < NUM_SRC; i++) begin
            shadow_q[i] <= '0;
         end
      end else begin
         state_q  <= state_d;
         ack_q    <= ack_d;
         loaded_q <= loaded_d;
         cur_q    <= cur_d;
         dwell_q  <= dwell_d;
         disp_q   <= disp_d;
         blank_q  <= blank_d;
         tick_q   <= tick_d;
         for (int i = 0; i < NUM_SRC; i++) begin
            shadow_q[i] <= shadow_d[i];
         end
      end
   end

   assign src_ack_o    = ack_q;
   assign disp_data_o  = disp_q;
   assign disp_src_o   = cur_q;
   assign disp_blank_o = blank_q;
   assign dwell_tick_o = tick_q;

endmodule
